// File: rtl/exhaustive_vector_checker_pkg.sv
// Shared types and constants for the exhaustive 4-input truth-table checker.
//   state_e    : sweep FSM encoding (IDLE / RUN / DONE)
//   chk_regs_t : every register of the checker datapath, kept together so
//                the next-state logic can start from a one-line default copy
package exhaustive_vector_checker_pkg;

    localparam int unsigned NUM_VEC = 16;
    localparam int unsigned VEC_W   = 4;
    localparam int unsigned ERR_W   = 5;

    localparam logic [VEC_W-1:0] LAST_IDX = VEC_W'(NUM_VEC - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    typedef struct packed {
        logic [VEC_W-1:0]   idx;             // vector presented on A..D
        logic [NUM_VEC-1:0] mask;            // expected truth table latched at start
        logic [NUM_VEC-1:0] captured;        // sampled f per index
        logic [ERR_W-1:0]   err_count;
        logic               first_err_valid;
        logic [VEC_W-1:0]   first_err_idx;
        logic               busy;
        logic               done;
        logic               pass;
    } chk_regs_t;

endpackage

// File: rtl/exhaustive_vector_checker_if.sv
// Signal bundle between the checker and the combinational block under test.
//   master : the side that requests sweeps and hosts the block under test
//            (drives start, exp_mask, f; observes vector and results)
//   slave  : the checker itself
interface exhaustive_vector_checker_if;
    import exhaustive_vector_checker_pkg::*;

    logic               start;
    logic [NUM_VEC-1:0] exp_mask;
    logic               f;
    logic               A;
    logic               B;
    logic               C;
    logic               D;
    logic               busy;
    logic               done;
    logic               pass;
    logic [NUM_VEC-1:0] captured;
    logic [ERR_W-1:0]   err_count;
    logic               first_err_valid;
    logic [VEC_W-1:0]   first_err_idx;

    modport master (
        output start, exp_mask, f,
        input  A, B, C, D, busy, done, pass, captured, err_count,
               first_err_valid, first_err_idx
    );

    modport slave (
        input  start, exp_mask, f,
        output A, B, C, D, busy, done, pass, captured, err_count,
               first_err_valid, first_err_idx
    );

endinterface

// File: rtl/exhaustive_vector_checker_dwell_counter.sv
// Dwell timer: counts clock cycles while en is high and flags the last cycle
// of each DWELL-long window.
//   clk, rst : clock, asynchronous active-high reset
//   clr      : restart the window (takes priority over en)
//   en       : count this cycle
//   tc       : combinational, high when en is set on the final cycle of a window
module exhaustive_vector_checker_dwell_counter #(
    parameter int unsigned DWELL = 20
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic tc
);

    localparam int unsigned CNT_W = (DWELL > 1) ? $clog2(DWELL) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DWELL - 1);

    logic [CNT_W-1:0] cnt_q;

    assign tc = en && (cnt_q == CNT_MAX);

    // Wraps to zero at the end of each window so the next vector starts fresh.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else if (clr) begin
            cnt_q <= '0;
        end else if (en) begin
            if (cnt_q == CNT_MAX) begin
                cnt_q <= '0;
            end else begin
                cnt_q <= cnt_q + CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/exhaustive_vector_checker.sv
// Exhaustive checker for a 4-input combinational block: presents vectors
// 0..15 on {A,B,C,D}, holds each for DWELL cycles, samples f at the end of the
// dwell, and compares the captured truth table with the latched expected mask.
//   clk, rst : clock, asynchronous active-high reset
//   bus      : slave side of exhaustive_vector_checker_if
//              in : start, exp_mask, f
//              out: A..D, busy, done, pass, captured, err_count,
//                   first_err_valid, first_err_idx (all registered)
module exhaustive_vector_checker
    import exhaustive_vector_checker_pkg::*;
#(
    parameter int unsigned DWELL = 20
) (
    input  logic                        clk,
    input  logic                        rst,
    exhaustive_vector_checker_if.slave  bus
);

    state_e           state_q;
    state_e           state_d;
    chk_regs_t        r_q;
    chk_regs_t        r_d;
    logic             start_acc_c;
    logic             tc;
    logic [ERR_W-1:0] err_nxt;

    // A start is only honoured outside a sweep; there is no abort.
    assign start_acc_c = bus.start && (state_q != ST_RUN);

    exhaustive_vector_checker_dwell_counter #(
        .DWELL (DWELL)
    ) u_dwell (
        .clk (clk),
        .rst (rst),
        .clr (start_acc_c),
        .en  (state_q == ST_RUN),
        .tc  (tc)
    );

    // State and datapath registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            r_q     <= '0;
        end else begin
            state_q <= state_d;
            r_q     <= r_d;
        end
    end

    // Next-state, capture and compare logic.
    always_comb begin
        state_d = state_q;
        r_d     = r_q;
        err_nxt = r_q.err_count;

        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start_acc_c) begin
                    state_d           = ST_RUN;
                    r_d.mask          = bus.exp_mask;
                    r_d.captured      = '0;
                    r_d.err_count     = '0;
                    r_d.first_err_valid = 1'b0;
                    r_d.first_err_idx = '0;
                    r_d.idx           = '0;
                    r_d.busy          = 1'b1;
                    r_d.done          = 1'b0;
                    r_d.pass          = 1'b0;
                end
            end

            ST_RUN: begin
                if (tc) begin
                    r_d.captured[r_q.idx] = bus.f;
                    if (bus.f != r_q.mask[r_q.idx]) begin
                        err_nxt       = r_q.err_count + ERR_W'(1);
                        r_d.err_count = err_nxt;
                        if (!r_q.first_err_valid) begin
                            r_d.first_err_valid = 1'b1;
                            r_d.first_err_idx   = r_q.idx;
                        end
                    end
                    // Leaving at the last index means idx never needs to wrap;
                    // it returns to zero so A..D read 0 while results are held.
                    if (r_q.idx == LAST_IDX) begin
                        state_d  = ST_DONE;
                        r_d.idx  = '0;
                        r_d.busy = 1'b0;
                        r_d.done = 1'b1;
                        r_d.pass = (err_nxt == '0);
                    end else begin
                        r_d.idx = r_q.idx + VEC_W'(1);
                    end
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign bus.A               = r_q.idx[3];
    assign bus.B               = r_q.idx[2];
    assign bus.C               = r_q.idx[1];
    assign bus.D               = r_q.idx[0];
    assign bus.busy            = r_q.busy;
    assign bus.done            = r_q.done;
    assign bus.pass            = r_q.pass;
    assign bus.captured        = r_q.captured;
    assign bus.err_count       = r_q.err_count;
    assign bus.first_err_valid = r_q.first_err_valid;
    assign bus.first_err_idx   = r_q.first_err_idx;

endmodule

// File: tb/tb_exhaustive_vector_checker.sv
// Bench for exhaustive_vector_checker: four checker instances with different
// dwell lengths, each wrapped around a truth-table-driven function block.
// A timing-level model (results as a function of edges since the accepted
// start) is compared against every instance after every clock edge.
module tb_exhaustive_vector_checker;

    localparam int NL = 4;

    function automatic int dw_of(input int g);
        case (g)
            0:       return 2;
            1:       return 1;
            2:       return 20;
            default: return 4;
        endcase
    endfunction

    // Truth table of the function blocks used by the plan, index = {A,B,C,D}.
    function automatic logic [15:0] tt_of(input int sel);
        logic [15:0] t;
        logic [3:0]  v;
        t = '0;
        for (int i = 0; i < 16; i++) begin
            v = 4'(i);
            case (sel)
                0:       t[i] = v[0];          // f = D
                1:       t[i] = v[3] & v[2];   // f = A & B
                2:       t[i] = 1'b0;          // f = 0
                3:       t[i] = ~v[1];         // f = ~C
                default: t[i] = v[2];          // f = B
            endcase
        end
        return t;
    endfunction

    logic        clk = 1'b0;
    logic        rst;
    logic        start_r [NL];
    logic [15:0] mask_r  [NL];
    logic [15:0] ftab    [NL];

    logic [3:0]  vec_o  [NL];
    logic        busy_o [NL];
    logic        done_o [NL];
    logic        pass_o [NL];
    logic [15:0] cap_o  [NL];
    logic [4:0]  err_o  [NL];
    logic        fev_o  [NL];
    logic [3:0]  fei_o  [NL];

    int errors = 0;
    int checks = 0;
    int cyc    = 0;

    bit          m_act  [NL];
    int          m_st   [NL];
    logic [15:0] m_mask [NL];
    logic [15:0] m_tt   [NL];

    always #5 clk = ~clk;

    for (genvar g = 0; g < NL; g++) begin : lane
        exhaustive_vector_checker_if bus_if ();

        assign bus_if.start    = start_r[g];
        assign bus_if.exp_mask = mask_r[g];
        assign bus_if.f        = ftab[g][{bus_if.A, bus_if.B, bus_if.C, bus_if.D}];

        exhaustive_vector_checker #(
            .DWELL (dw_of(g))
        ) dut (
            .clk (clk),
            .rst (rst),
            .bus (bus_if)
        );

        assign vec_o[g]  = {bus_if.A, bus_if.B, bus_if.C, bus_if.D};
        assign busy_o[g] = bus_if.busy;
        assign done_o[g] = bus_if.done;
        assign pass_o[g] = bus_if.pass;
        assign cap_o[g]  = bus_if.captured;
        assign err_o[g]  = bus_if.err_count;
        assign fev_o[g]  = bus_if.first_err_valid;
        assign fei_o[g]  = bus_if.first_err_idx;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
        end
    endtask

    // Model update at each edge, then comparison of every lane just after it.
    always @(posedge clk) begin
        cyc++;
        for (int l = 0; l < NL; l++) begin
            if (rst) begin
                m_act[l] = 1'b0;
            end else if (start_r[l] &&
                         (!m_act[l] || (cyc - 1 - m_st[l]) >= 16 * dw_of(l))) begin
                m_act[l]  = 1'b1;
                m_st[l]   = cyc;
                m_mask[l] = mask_r[l];
                m_tt[l]   = ftab[l];
            end
        end
        #1;
        for (int l = 0; l < NL; l++) begin
            int          n;
            int          e;
            bit          fv;
            logic [3:0]  fi;
            logic [15:0] cap;
            logic [3:0]  ev;
            bit          eb;
            bit          ed;
            bit          ep;
            e = 0; fv = 1'b0; fi = '0; cap = '0; ev = '0; eb = 1'b0; ed = 1'b0; ep = 1'b0;
            if (m_act[l]) begin
                n = (cyc - m_st[l]) / dw_of(l);
                if (n > 16) n = 16;
                for (int i = 0; i < n; i++) begin
                    cap[i] = m_tt[l][i];
                    if (m_tt[l][i] != m_mask[l][i]) begin
                        e++;
                        if (!fv) begin
                            fv = 1'b1;
                            fi = 4'(i);
                        end
                    end
                end
                if (n < 16) begin
                    eb = 1'b1;
                    ev = 4'(n);
                end else begin
                    ed = 1'b1;
                    ep = (e == 0);
                end
            end
            chk($sformatf("L%0d vector", l),   vec_o[l],  ev);
            chk($sformatf("L%0d busy", l),     busy_o[l], eb);
            chk($sformatf("L%0d done", l),     done_o[l], ed);
            chk($sformatf("L%0d pass", l),     pass_o[l], ep);
            chk($sformatf("L%0d captured", l), cap_o[l],  cap);
            chk($sformatf("L%0d err_count", l), err_o[l], e);
            chk($sformatf("L%0d first_err_valid", l), fev_o[l], fv);
            chk($sformatf("L%0d first_err_idx", l),   fei_o[l], fi);
        end
    end

    // Start pulse covering exactly one rising edge; returns just after it.
    task automatic pulse_start(input int l, input logic [15:0] m, output int t0);
        @(negedge clk);
        mask_r[l]  = m;
        start_r[l] = 1'b1;
        @(negedge clk);
        start_r[l] = 1'b0;
        t0 = cyc;
    endtask

    task automatic wait_done(input int l, input int budget);
        int n;
        n = 0;
        while (done_o[l] !== 1'b1 && n < budget) begin
            @(negedge clk);
            n++;
        end
        chk($sformatf("L%0d done reached", l), done_o[l], 1);
    endtask

    task automatic wait_vec(input int l, input logic [3:0] v, input int budget);
        int n;
        n = 0;
        while (vec_o[l] !== v && n < budget) begin
            @(negedge clk);
            n++;
        end
        chk($sformatf("L%0d vector reached", l), vec_o[l], v);
    endtask

    initial begin
        int t0;
        int ln;
        logic [15:0] rm;
        rst = 1'b1;
        for (int l = 0; l < NL; l++) begin
            start_r[l] = 1'b0;
            mask_r[l]  = '0;
        end
        ftab[0] = tt_of(0);
        ftab[1] = tt_of(2);
        ftab[2] = tt_of(3);
        ftab[3] = tt_of(4);
        repeat (2) @(negedge clk);
        chk("reset busy", busy_o[0], 0);
        chk("reset done", done_o[0], 0);
        chk("reset vector", vec_o[0], 0);
        rst = 1'b0;

        // f = D against 0xAAAA: clean pass after 32 edges.
        pulse_start(0, 16'hAAAA, t0);
        wait_done(0, 100);
        chk("t1 sweep edges", cyc - t0, 32);
        chk("t1 captured", cap_o[0], 16'hAAAA);
        chk("t1 err_count", err_o[0], 0);
        chk("t1 pass", pass_o[0], 1);
        chk("t1 first_err_valid", fev_o[0], 0);

        // f = A&B against 0xF001: single miss at index 0.
        ftab[0] = tt_of(1);
        pulse_start(0, 16'hF001, t0);
        wait_done(0, 100);
        chk("t2 captured", cap_o[0], 16'hF000);
        chk("t2 err_count", err_o[0], 1);
        chk("t2 first_err_idx", fei_o[0], 0);
        chk("t2 first_err_valid", fev_o[0], 1);
        chk("t2 pass", pass_o[0], 0);

        // DWELL=1, f = 0 against all-ones: every index fails.
        pulse_start(1, 16'hFFFF, t0);
        wait_done(1, 50);
        chk("t3 sweep edges", cyc - t0, 16);
        chk("t3 err_count", err_o[1], 16);
        chk("t3 first_err_idx", fei_o[1], 0);
        chk("t3 captured", cap_o[1], 16'h0000);
        chk("t3 pass", pass_o[1], 0);

        // DWELL=20, f = ~C; rerun from DONE with an ignored start mid-sweep.
        pulse_start(2, 16'h3333, t0);
        wait_done(2, 400);
        chk("t4 pass", pass_o[2], 1);
        pulse_start(2, 16'h3333, t0);
        chk("t4 rerun clears done", done_o[2], 0);
        wait_vec(2, 4'd5, 200);
        pulse_start(2, 16'h0000, ln);
        wait_done(2, 400);
        chk("t4 rerun edges", cyc - t0, 320);
        chk("t4 rerun captured", cap_o[2], 16'h3333);
        chk("t4 rerun pass", pass_o[2], 1);

        // DWELL=4, f = B; asynchronous reset in the middle of index 7.
        pulse_start(3, 16'hF0F0, t0);
        wait_vec(3, 4'd7, 100);
        rst = 1'b1;
        #1;
        chk("t5 rst vector", vec_o[3], 0);
        chk("t5 rst busy", busy_o[3], 0);
        chk("t5 rst captured", cap_o[3], 0);
        chk("t5 rst err_count", err_o[3], 0);
        chk("t5 rst other lane done", done_o[2], 0);
        @(negedge clk);
        rst = 1'b0;
        pulse_start(3, 16'hF0F0, t0);
        wait_done(3, 100);
        chk("t5 captured", cap_o[3], 16'hF0F0);
        chk("t5 pass", pass_o[3], 1);

        // Back-to-back: new start on the first edge after done, new mask.
        ftab[0] = tt_of(0);
        pulse_start(0, 16'hAAAA, t0);
        wait_done(0, 100);
        mask_r[0]  = 16'h5555;
        start_r[0] = 1'b1;
        @(negedge clk);
        start_r[0] = 1'b0;
        chk("t6 done cleared", done_o[0], 0);
        chk("t6 busy", busy_o[0], 1);
        wait_done(0, 100);
        chk("t6 err_count", err_o[0], 16);
        chk("t6 pass", pass_o[0], 0);

        // Random truth tables and masks on the short-dwell lanes.
        for (int r = 0; r < 8; r++) begin
            ln = (r % 2 == 0) ? 1 : 3;
            ftab[ln] = 16'($urandom);
            rm = (r % 3 == 0) ? ftab[ln] : 16'($urandom);
            pulse_start(ln, rm, t0);
            wait_done(ln, 100);
            chk("rand err_count", err_o[ln], $countones(ftab[ln] ^ rm));
            chk("rand pass", pass_o[ln], (ftab[ln] == rm) ? 1 : 0);
        end

        repeat (3) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
